// File: rtl/rx_sync_monitor_pkg.sv
// Shared definitions for the receive sync monitor: lock-state encoding
// and the width helper used to size its saturating counters.
package rx_sync_monitor_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_SUSPECT = 2'd2,
        ST_LOST    = 2'd3
    } lock_state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rx_frame_checker.sv
// Per-frame integrity checker: guard bits at each visible line end,
// optional visible line count, and a commit strobe on VSYNC fall.
module rx_frame_checker
    import rx_sync_monitor_pkg::*;
#(
    parameter int VIDEO_W    = 10,
    parameter int GUARD_BITS = 4,
    parameter int EXP_LINES  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               visible,
    input  logic [VIDEO_W-1:0] video,
    input  logic               vsync,
    output logic               commit,
    output logic               bad
);

    localparam int LC_RAW = clog2(EXP_LINES + 2);
    localparam int LC_W   = (LC_RAW < 1) ? 1 : LC_RAW;
    localparam logic [LC_W-1:0] LC_MAX = '1;
    localparam logic [LC_W-1:0] LC_EXP = LC_W'(EXP_LINES);

    logic            prev_visible_q, prev_visible_d;
    logic            prev_vsync_q, prev_vsync_d;
    logic            frame_bad_q, frame_bad_d;
    logic [LC_W-1:0] line_cnt_q, line_cnt_d;

    logic            line_end;
    logic            line_ev;
    logic            guard_hit;
    logic            bad_acc;
    logic [LC_W-1:0] cnt_acc;
    logic            len_bad;

    // Only the guard MSBs matter; the remaining pixel bits are don't-care.
    logic unused_video;
    assign unused_video = ^video;

    always_comb begin
        line_end  = !visible && prev_visible_q;
        guard_hit = |video[VIDEO_W-1 -: GUARD_BITS];
        commit    = prev_vsync_q && !vsync;
        // A line end on the commit cycle still belongs to the closing frame.
        line_ev   = line_end && (vsync || commit);

        bad_acc = frame_bad_q | (line_ev & guard_hit);
        cnt_acc = line_cnt_q;
        if (line_ev && (line_cnt_q != LC_MAX)) begin
            cnt_acc = line_cnt_q + LC_W'(1);
        end

        len_bad = (EXP_LINES != 0) && (cnt_acc != LC_EXP);
        bad     = bad_acc | len_bad;

        prev_visible_d = visible;
        prev_vsync_d   = vsync;
        frame_bad_d    = 1'b0;
        line_cnt_d     = '0;
        if (vsync) begin
            frame_bad_d = bad_acc;
            line_cnt_d  = cnt_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_visible_q <= 1'b0;
            prev_vsync_q   <= 1'b0;
            frame_bad_q    <= 1'b0;
            line_cnt_q     <= '0;
        end else begin
            prev_visible_q <= prev_visible_d;
            prev_vsync_q   <= prev_vsync_d;
            frame_bad_q    <= frame_bad_d;
            line_cnt_q     <= line_cnt_d;
        end
    end

endmodule

// File: rtl/rx_sync_monitor.sv
// Frame-level receive sync monitor with hysteretic lock FSM and resync pulse.
// Define RX_SYNC_MON_STATS_EN to add the saturating BAD_FRAMES counter port.
module rx_sync_monitor
    import rx_sync_monitor_pkg::*;
#(
    parameter int VIDEO_W     = 10,
    parameter int GUARD_BITS  = 4,
    parameter int EXP_LINES   = 0,
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 3
`ifdef RX_SYNC_MON_STATS_EN
    ,
    parameter int STAT_W      = 16
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VISIBLE,
    input  logic [VIDEO_W-1:0] VIDEO,
    input  logic               VSYNC,
    output logic               SYNC_BAD,
    output logic               LOCKED,
    output logic               RESYNC_REQ,
    output logic [1:0]         STATE
`ifdef RX_SYNC_MON_STATS_EN
    ,
    output logic [STAT_W-1:0]  BAD_FRAMES
`endif
);

    localparam int GC_W = clog2(LOCK_FRAMES) + 1;
    localparam int BC_W = clog2(LOSS_FRAMES) + 1;
    localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_FRAMES);
    localparam logic [BC_W-1:0] BC_LOSS = BC_W'(LOSS_FRAMES);

    logic commit;
    logic bad;

    rx_frame_checker #(
        .VIDEO_W    (VIDEO_W),
        .GUARD_BITS (GUARD_BITS),
        .EXP_LINES  (EXP_LINES)
    ) u_checker (
        .clk     (CLK),
        .rst     (RST),
        .visible (VISIBLE),
        .video   (VIDEO),
        .vsync   (VSYNC),
        .commit  (commit),
        .bad     (bad)
    );

    lock_state_e     state_q, state_d;
    logic [GC_W-1:0] good_cnt_q, good_cnt_d;
    logic [BC_W-1:0] bad_cnt_q, bad_cnt_d;
    logic            sync_bad_q, sync_bad_d;
    logic [GC_W-1:0] good_inc;
    logic [BC_W-1:0] bad_inc;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        sync_bad_d = commit ? bad : sync_bad_q;
        good_inc   = good_cnt_q + GC_W'(1);
        bad_inc    = bad_cnt_q + BC_W'(1);

        unique case (state_q)
            ST_ACQUIRE: begin
                if (commit) begin
                    if (bad) begin
                        good_cnt_d = '0;
                    end else if (good_inc == GC_LOCK) begin
                        good_cnt_d = '0;
                        state_d    = ST_LOCKED;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (commit && bad) begin
                    bad_cnt_d = BC_W'(1);
                    state_d   = (LOSS_FRAMES == 1) ? ST_LOST : ST_SUSPECT;
                end
            end
            ST_SUSPECT: begin
                if (commit) begin
                    if (!bad) begin
                        bad_cnt_d = '0;
                        state_d   = ST_LOCKED;
                    end else begin
                        bad_cnt_d = bad_inc;
                        if (bad_inc == BC_LOSS) begin
                            state_d = ST_LOST;
                        end
                    end
                end
            end
            ST_LOST: begin
                // Single-cycle state: the resync pulse is its only output.
                state_d    = ST_ACQUIRE;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
            end
            default: begin
                state_d = ST_ACQUIRE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_ACQUIRE;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            sync_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            sync_bad_q <= sync_bad_d;
        end
    end

    assign STATE      = state_q;
    assign LOCKED     = (state_q == ST_LOCKED) || (state_q == ST_SUSPECT);
    assign RESYNC_REQ = (state_q == ST_LOST);
    assign SYNC_BAD   = sync_bad_q;

`ifdef RX_SYNC_MON_STATS_EN
    logic [STAT_W-1:0] bad_frames_q, bad_frames_d;

    always_comb begin
        bad_frames_d = bad_frames_q;
        if (commit && bad && (bad_frames_q != '1)) begin
            bad_frames_d = bad_frames_q + STAT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bad_frames_q <= '0;
        end else begin
            bad_frames_q <= bad_frames_d;
        end
    end

    assign BAD_FRAMES = bad_frames_q;
`endif

endmodule

// File: tb/tb_rx_sync_monitor.sv
// Randomized bench for rx_sync_monitor: two instances (no line check and
// 480-line check) share stimulus and are compared against a frame-level model.
module tb_rx_sync_monitor;

    localparam int VW     = 10;
    localparam int GB     = 4;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
    localparam int NEXP   = 480;
`ifdef RX_SYNC_MON_STATS_EN
    localparam int SW     = 2;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          VISIBLE;
    logic          VSYNC;
    logic [VW-1:0] VIDEO;

    logic       sb [2];
    logic       lk [2];
    logic       rr [2];
    logic [1:0] st [2];
`ifdef RX_SYNC_MON_STATS_EN
    logic [SW-1:0] bf [2];
`endif

    always #5 CLK = ~CLK;

    rx_sync_monitor #(
        .VIDEO_W     (VW),
        .GUARD_BITS  (GB),
        .EXP_LINES   (0),
        .LOCK_FRAMES (LOCK_N),
        .LOSS_FRAMES (LOSS_N)
`ifdef RX_SYNC_MON_STATS_EN
        ,
        .STAT_W      (SW)
`endif
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .VISIBLE    (VISIBLE),
        .VIDEO      (VIDEO),
        .VSYNC      (VSYNC),
        .SYNC_BAD   (sb[0]),
        .LOCKED     (lk[0]),
        .RESYNC_REQ (rr[0]),
        .STATE      (st[0])
`ifdef RX_SYNC_MON_STATS_EN
        ,
        .BAD_FRAMES (bf[0])
`endif
    );

    rx_sync_monitor #(
        .VIDEO_W     (VW),
        .GUARD_BITS  (GB),
        .EXP_LINES   (NEXP),
        .LOCK_FRAMES (LOCK_N),
        .LOSS_FRAMES (LOSS_N)
`ifdef RX_SYNC_MON_STATS_EN
        ,
        .STAT_W      (SW)
`endif
    ) u_dut_lc (
        .CLK        (CLK),
        .RST        (RST),
        .VISIBLE    (VISIBLE),
        .VIDEO      (VIDEO),
        .VSYNC      (VSYNC),
        .SYNC_BAD   (sb[1]),
        .LOCKED     (lk[1]),
        .RESYNC_REQ (rr[1]),
        .STATE      (st[1])
`ifdef RX_SYNC_MON_STATS_EN
        ,
        .BAD_FRAMES (bf[1])
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Frame-level reference: lock state, consecutive good/bad runs, last result.
    int m_st   [2];
    int m_good [2];
    int m_bad  [2];
    int m_bf   [2];
    bit m_sb   [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i]   = 0;
            m_good[i] = 0;
            m_bad[i]  = 0;
            m_bf[i]   = 0;
            m_sb[i]   = 1'b0;
        end
    endtask

    task automatic model_commit(input bit fb, input int cnt);
        bit b;
        for (int i = 0; i < 2; i++) begin
            b = fb || (i == 1 && cnt != NEXP);
            m_sb[i] = b;
            if (b && m_bf[i] < 3) m_bf[i]++;
            case (m_st[i])
                0: begin
                    if (b) m_good[i] = 0;
                    else begin
                        m_good[i]++;
                        if (m_good[i] == LOCK_N) begin
                            m_st[i]   = 1;
                            m_good[i] = 0;
                        end
                    end
                end
                1: begin
                    if (b) begin
                        m_bad[i] = 1;
                        m_st[i]  = (LOSS_N == 1) ? 3 : 2;
                    end
                end
                2: begin
                    if (!b) begin
                        m_bad[i] = 0;
                        m_st[i]  = 1;
                    end else begin
                        m_bad[i]++;
                        if (m_bad[i] == LOSS_N) m_st[i] = 3;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.sync_bad[%0d]", tag, i), 32'(sb[i]), 32'(m_sb[i]));
            check($sformatf("%s.state[%0d]", tag, i), 32'(st[i]), 32'(m_st[i]));
            check($sformatf("%s.locked[%0d]", tag, i), 32'(lk[i]),
                  32'(m_st[i] == 1 || m_st[i] == 2));
            check($sformatf("%s.resync[%0d]", tag, i), 32'(rr[i]),
                  32'(m_st[i] == 3));
`ifdef RX_SYNC_MON_STATS_EN
            check($sformatf("%s.bad_frames[%0d]", tag, i), 32'(bf[i]),
                  32'(m_bf[i]));
`endif
        end
    endtask

    function automatic bit guard_hit(input logic [VW-1:0] v);
        return (v >> (VW - GB)) != 0;
    endfunction

    function automatic logic [VW-1:0] clean_val();
        return VW'($urandom_range(0, (1 << (VW - GB)) - 1));
    endfunction

    task automatic drive(input logic vis, input logic [VW-1:0] vid,
                         input logic vs);
        @(negedge CLK);
        VISIBLE = vis;
        VIDEO   = vid;
        VSYNC   = vs;
    endtask

    task automatic commit_check(input string tag, input bit fb, input int cnt);
        @(posedge CLK);
        #1;
        model_commit(fb, cnt);
        check_outs(tag);
        if (m_st[0] == 3 || m_st[1] == 3) begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (m_st[i] == 3) begin
                    m_st[i]   = 0;
                    m_good[i] = 0;
                    m_bad[i]  = 0;
                end
            end
            check_outs({tag, ".after_lost"});
        end
    endtask

    // Blanking (with an ignored dirty line end), nl visible lines, VSYNC fall.
    task automatic run_frame(input string tag, input int nl, input int badln,
                             input logic [VW-1:0] badv, input bit fold);
        logic [VW-1:0] v;
        bit            fb;
        fb = 1'b0;
        drive(1'b0, '0, 1'b0);
        drive(1'b1, VW'($urandom), 1'b0);
        drive(1'b0, VW'(10'h3C0), 1'b0);
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < nl; i++) begin
            drive(1'b1, VW'($urandom), 1'b1);
            v  = (i == badln) ? badv : clean_val();
            fb = fb | guard_hit(v);
            drive(1'b0, v, (fold && i == nl - 1) ? 1'b0 : 1'b1);
        end
        if (!fold) drive(1'b0, clean_val(), 1'b0);
        commit_check(tag, fb, nl);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'($urandom), VW'($urandom), 1'b0);
        end
        drive(1'b0, '0, 1'b0);
        @(posedge CLK);
        #1;
        check_outs("idle");
    endtask

    initial begin
        int            nl;
        int            badln;
        logic [VW-1:0] badv;

        RST     = 1'b1;
        VISIBLE = 1'b0;
        VSYNC   = 1'b0;
        VIDEO   = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_outs("reset");
        @(negedge CLK);
        RST = 1'b0;

        for (int f = 0; f < 4; f++) run_frame("clean", 3, -1, '0, 1'b0);
        check("lock.state", 32'(st[0]), 32'd1);

        run_frame("bad_200", 3, 1, VW'(10'h200), 1'b0);
        check("suspect.state", 32'(st[0]), 32'd2);
        run_frame("recover", 3, -1, '0, 1'b0);

        for (int f = 0; f < 3; f++) run_frame("loss", 2, 0, VW'(10'h100), 1'b0);
        for (int f = 0; f < 4; f++) run_frame("relock", 2, -1, '0, 1'b0);

        run_frame("lines_479", 479, -1, '0, 1'b0);
        run_frame("lines_480", 480, -1, '0, 1'b0);
        run_frame("lines_480_fold", 480, -1, '0, 1'b1);

        run_frame("fold_040", 3, 2, VW'(10'h040), 1'b1);
        idle(5);

        for (int f = 0; f < 40; f++) begin
            nl    = $urandom_range(1, 6);
            badln = ($urandom_range(0, 4) < 2) ? $urandom_range(0, nl - 1) : -1;
            badv  = clean_val() | (VW'($urandom_range(1, 15)) << (VW - GB));
            run_frame("rand", nl, badln, badv, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
        end

        for (int f = 0; f < 4; f++) run_frame("pre_rst", 2, -1, '0, 1'b0);
        run_frame("pre_rst_bad", 2, 0, VW'(10'h3FF), 1'b0);

        drive(1'b0, '0, 1'b0);
        drive(1'b1, VW'($urandom), 1'b1);
        drive(1'b0, VW'(10'h3FF), 1'b1);
        drive(1'b1, VW'($urandom), 1'b1);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_outs("async_rst");
        @(negedge CLK);
        VISIBLE = 1'b0;
        VSYNC   = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        run_frame("post_rst", 2, -1, '0, 1'b0);
        for (int f = 0; f < 5; f++) run_frame("stats", 2, 1, VW'(10'h080), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
